seq_restoring_divider: RTL

Sequential unsigned restoring divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock, using repeated conditional subtraction. It sits beside the combinational 4-bit adder/subtractor in the arithmetic library and is the inverse-direction operator that the datapath needs for division. It uses a start/done handshake toward the controlling FSM.

---
 rtl/arith_pkg.sv | 18 +
 rtl/divider_sub_stage.sv | 19 +
 rtl/seq_restoring_divider.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM states, default operand
// width and the iteration-counter width helper.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Bits needed to count 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_sub_stage.sv
// Combinational W-bit trial subtraction with borrow-out; the divider's use of
// the arithmetic library's adder/subtractor datapath.
module divider_sub_stage
    import arith_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH + 1
) (
    input  logic [W-1:0] minuend_i,
    input  logic [W-1:0] subtrahend_i,
    output logic [W-1:0] diff_o,
    output logic         no_borrow_o
);

    logic borrow;

    assign {borrow, diff_o} = {1'b0, minuend_i} - {1'b0, subtrahend_i};
    assign no_borrow_o      = ~borrow;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Optional macro DIVIDER_DBZ_CHECK_EN short-cuts divide-by-zero.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;
    logic             no_borrow;
    logic             last_iter;
    logic             zero_in;
    logic             zero_held;
    logic             r_msb_unused;

    assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    divider_sub_stage #(
        .W(WIDTH + 1)
    ) u_sub_stage (
        .minuend_i   (shifted),
        .subtrahend_i({1'b0, divisor_q}),
        .diff_o      (trial),
        .no_borrow_o (no_borrow)
    );

    assign r_d          = no_borrow ? trial : shifted;
    assign q_d          = {q_q[WIDTH-2:0], no_borrow};
    assign last_iter    = (cnt_q == CW'(WIDTH - 1));
    // After every restore step R < divisor, so the top bit of R is always zero.
    assign r_msb_unused = r_q[WIDTH];

`ifdef DIVIDER_DBZ_CHECK_EN
    assign zero_in   = (divisor == '0);
    assign zero_held = (divisor_q == '0);
`else
    assign zero_in   = 1'b0;
    assign zero_held = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        q_q       <= dividend;
                        divisor_q <= divisor;
                        r_q       <= '0;
                        cnt_q     <= '0;
                        busy_q    <= ~zero_in;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (zero_held) begin
                        // q_q still holds the untouched dividend on this path.
                        quotient_q  <= '1;
                        remainder_q <= q_q;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        r_q   <= r_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_iter) begin
                            quotient_q  <= q_d;
                            remainder_q <= r_d[WIDTH-1:0];
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DIVIDER_DBZ_CHECK_EN
    logic dbz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            dbz_q <= 1'b0;
        end else if (state_q == RUN && zero_held) begin
            dbz_q <= 1'b1;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
